// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Serial PRBS checker for the right-shifting Fibonacci LFSR
//               generator. It self-synchronises by filling a shadow register
//               from received bits, verifies a run of predictions, then
//               counts mismatches while locked.
// Option      : `define LFSR_CHECKER_BITCOUNT_EN adds the bit_count port and
//               its saturating counter of bits compared while locked.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
  parameter int Width     = 7,
  parameter int LockCount = 8,
  parameter int ErrLimit  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        clear,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count
`ifdef LFSR_CHECKER_BITCOUNT_EN
  ,
  output logic [31:0] bit_count
`endif
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] c_fill_last = 4'(Width);
  localparam logic [7:0] c_lock_cnt  = 8'(LockCount);
  localparam logic [3:0] c_err_limit = 4'(ErrLimit);

  state_t             r_state;
  logic [Width-1:0]   r_shadow;
  logic [3:0]         r_fill_cnt;
  logic [7:0]         r_good_cnt;
  logic [3:0]         r_bad_cnt;
  logic               r_locked;
  logic               r_err;
  logic [15:0]        r_err_count;

  logic               w_pred;
  logic               w_zero;
  logic               w_mismatch;
  logic               w_count_err;

  // Parameter range checks: any out-of-range value stops elaboration.
  if (LockCount < 1 || LockCount > 255) begin : g_bad_lock_count
    $error("lfsr_checker: LockCount must be in 1..255");
  end
  if (ErrLimit < 1 || ErrLimit > 15) begin : g_bad_err_limit
    $error("lfsr_checker: ErrLimit must be in 1..15");
  end

  // Feedback taps, shared with the generator; only the selected branch is built.
  case (Width)
    3, 4, 6, 7: begin : g_tap_1_0
      assign w_pred = r_shadow[1] ^ r_shadow[0];
    end
    5: begin : g_tap_5
      assign w_pred = r_shadow[2] ^ r_shadow[0];
    end
    8: begin : g_tap_8
      assign w_pred = r_shadow[4] ^ r_shadow[3] ^ r_shadow[2] ^ r_shadow[0];
    end
    9: begin : g_tap_9
      assign w_pred = r_shadow[4] ^ r_shadow[0];
    end
    default: begin : g_bad_width
      assign w_pred = 1'b0;
      $error("lfsr_checker: Width must be in 3..9");
    end
  endcase

  assign w_zero      = (r_shadow == '0);
  assign w_mismatch  = bit_in ^ w_pred;
  // A mismatch is only counted when locked and the lock-up guard is not firing.
  assign w_count_err = bit_valid && (r_state == ST_LOCKED) && !w_zero && w_mismatch;

  // Synchronisation FSM: fill, verify, then track the stream on predicted bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_SYNC;
      r_shadow   <= '0;
      r_fill_cnt <= 4'd0;
      r_good_cnt <= 8'd0;
      r_bad_cnt  <= 4'd0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (bit_valid) begin
        case (r_state)
          ST_SYNC: begin
            r_shadow   <= {bit_in, r_shadow[Width-1:1]};
            r_fill_cnt <= r_fill_cnt + 4'd1;
            if (r_fill_cnt + 4'd1 == c_fill_last) begin
              r_state    <= ST_VERIFY;
              r_good_cnt <= 8'd0;
            end
          end
          ST_VERIFY: begin
            if (w_zero) begin
              // All-zero register would predict zeros forever; refill instead.
              r_state    <= ST_SYNC;
              r_fill_cnt <= 4'd0;
            end else begin
              r_shadow <= {bit_in, r_shadow[Width-1:1]};
              if (w_mismatch) begin
                // The offending bit is kept as the first bit of the new fill.
                r_state    <= ST_SYNC;
                r_fill_cnt <= 4'd1;
              end else begin
                r_good_cnt <= r_good_cnt + 8'd1;
                if (r_good_cnt + 8'd1 == c_lock_cnt) begin
                  r_state   <= ST_LOCKED;
                  r_locked  <= 1'b1;
                  r_bad_cnt <= 4'd0;
                end
              end
            end
          end
          ST_LOCKED: begin
            if (w_zero) begin
              r_state    <= ST_SYNC;
              r_fill_cnt <= 4'd0;
              r_locked   <= 1'b0;
            end else begin
              // Shift the prediction so a corrupted bit never enters the register.
              r_shadow <= {w_pred, r_shadow[Width-1:1]};
              if (w_mismatch) begin
                r_err     <= 1'b1;
                r_bad_cnt <= r_bad_cnt + 4'd1;
                if (r_bad_cnt + 4'd1 == c_err_limit) begin
                  r_state    <= ST_SYNC;
                  r_fill_cnt <= 4'd0;
                  r_locked   <= 1'b0;
                end
              end else begin
                r_bad_cnt <= 4'd0;
              end
            end
          end
          default: begin
            r_state    <= ST_SYNC;
            r_fill_cnt <= 4'd0;
            r_locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error counter; a same-cycle clear and error leaves a count of one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= 16'd0;
    end else if (clear) begin
      r_err_count <= w_count_err ? 16'd1 : 16'd0;
    end else if (w_count_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

`ifdef LFSR_CHECKER_BITCOUNT_EN
  logic        w_count_bit;
  logic [31:0] r_bit_count;

  assign w_count_bit = bit_valid && (r_state == ST_LOCKED) && !w_zero;

  // Saturating count of bits compared while locked, the BER denominator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_count <= 32'd0;
    end else if (clear) begin
      r_bit_count <= w_count_bit ? 32'd1 : 32'd0;
    end else if (w_count_bit && (r_bit_count != 32'hFFFF_FFFF)) begin
      r_bit_count <= r_bit_count + 32'd1;
    end
  end

  assign bit_count = r_bit_count;
`endif

  assign locked    = r_locked;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule
`default_nettype wire
